// File: rtl/restoring_divider_if.sv
// restoring_divider_if: operand/result bundle for the sequential restoring divider.
// Latency: none, this is wiring only.
// Backpressure: none. The requester holds start until it sees the accept, or re-issues start once busy drops.
//
// Signals:
//   start     requester -> divider   request a division (sampled only while idle)
//   dividend  requester -> divider   numerator, latched on the accepting edge
//   divisor   requester -> divider   denominator, latched on the accepting edge
//   busy      divider -> requester   high whenever the divider is not idle
//   done      divider -> requester   one-cycle pulse, results valid in that cycle
//   quotient  divider -> requester   held until the next accepted start
//   remainder divider -> requester   held until the next accepted start
//   dbz       divider -> requester   divide-by-zero flag for the current result
//   ovf       divider -> requester   signed overflow flag (most-negative / -1)
interface restoring_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         dbz;
    logic         ovf;

    // master issues requests; slave is the divider itself
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz, ovf
    );
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider: sequential N-bit restoring divider, one trial subtraction per clock.
// Latency: N+1 busy cycles from the accepting edge, done in the last of them; divide-by-zero gives 1 busy cycle.
// Backpressure: start is ignored while busy (including the done cycle). Results hold until the next accept.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any division in flight with no done pulse
//   divIf  restoring_divider_if.slave carrying start/dividend/divisor in and
//          busy/done/quotient/remainder/dbz/ovf out
//
// Build option: define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign, ovf flags
// most-negative / -1). Without it the divider is unsigned and ovf is tied to 0.
module restoring_divider #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    restoring_divider_if.slave divIf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    // Ripple-borrow subtractor: returns {borrowOut, difference[N-1:0]} of a - b.
    // The top difference bit is never needed, because the restore path only keeps
    // N bits of the trial value and the partial remainder stays below the divisor.
    function automatic logic [N:0] binarySubtract(input logic [N:0] a, input logic [N:0] b);
        logic         borrow;
        logic [N-1:0] diff;
        borrow = 1'b0;
        diff   = '0;
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                diff[i] = a[i] ^ b[i] ^ borrow;
            end
            borrow = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
        end
        return {borrow, diff};
    endfunction

`ifdef RESTORING_DIVIDER_SIGNED_EN
    function automatic logic [N-1:0] twosNeg(input logic [N-1:0] x);
        return ~x + 1'b1;
    endfunction

    logic qNeg;     // final quotient must be negated
    logic rNeg;     // final remainder must be negated
    logic ovfPend;  // operands were most-negative / -1
    logic ovfQ;
`endif

    logic [1:0]    state;
    logic [N-1:0]  accA;        // dividend shifting out, quotient bits shifting in
    logic [N-1:0]  divD;        // latched divisor (magnitude in signed builds)
    logic [N-1:0]  partP;       // partial remainder
    logic [CW-1:0] iterCount;
    logic [N-1:0]  quotientQ;
    logic [N-1:0]  remainderQ;
    logic          dbzQ;

    logic          accept;
    logic          divZero;
    logic          lastIter;
    logic [N-1:0]  opA;
    logic [N-1:0]  opD;
    logic [N:0]    trial;
    logic [N:0]    subRes;
    logic          borrowOut;
    logic [N-1:0]  nextP;
    logic [N-1:0]  nextA;
    logic [N-1:0]  finalQ;
    logic [N-1:0]  finalR;

    assign accept   = (state == IDLE) && divIf.start;
    assign divZero  = (divIf.divisor == '0);
    assign lastIter = (iterCount == LAST_ITER);

    // Operands as fed into the unsigned core.
    always_comb begin
        opA = divIf.dividend;
        opD = divIf.divisor;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        // |most-negative| still fits as an unsigned N-bit value
        if (divIf.dividend[N-1]) opA = twosNeg(divIf.dividend);
        if (divIf.divisor[N-1])  opD = twosNeg(divIf.divisor);
`endif
    end

    // One restoring step: trial = {P, next dividend bit}; keep the difference
    // when it did not borrow, otherwise keep the trial (the restore).
    always_comb begin
        trial     = {partP, accA[N-1]};
        subRes    = binarySubtract(trial, {1'b0, divD});
        borrowOut = subRes[N];
        nextP     = borrowOut ? trial[N-1:0] : subRes[N-1:0];
        nextA     = {accA[N-2:0], ~borrowOut};
    end

    // Results as registered on the final iteration edge.
    always_comb begin
        finalQ = nextA;
        finalR = nextP;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        if (qNeg) finalQ = twosNeg(nextA);
        if (rNeg) finalR = twosNeg(nextP);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            accA       <= '0;
            divD       <= '0;
            partP      <= '0;
            iterCount  <= '0;
            quotientQ  <= '0;
            remainderQ <= '0;
            dbzQ       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divZero) begin
                            // No iterations: results are fixed, done follows next cycle.
                            state      <= DONE;
                            quotientQ  <= '1;
                            remainderQ <= divIf.dividend;
                            dbzQ       <= 1'b1;
                        end else begin
                            state     <= RUN;
                            accA      <= opA;
                            divD      <= opD;
                            partP     <= '0;
                            iterCount <= '0;
                            dbzQ      <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    accA      <= nextA;
                    partP     <= nextP;
                    iterCount <= iterCount + 1'b1;
                    if (lastIter) begin
                        state      <= DONE;
                        quotientQ  <= finalQ;
                        remainderQ <= finalR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RESTORING_DIVIDER_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
            ovfPend <= 1'b0;
            ovfQ    <= 1'b0;
        end else if (accept) begin
            qNeg    <= divIf.dividend[N-1] ^ divIf.divisor[N-1];
            rNeg    <= divIf.dividend[N-1];
            ovfPend <= (divIf.dividend == {1'b1, {(N-1){1'b0}}}) && (divIf.divisor == '1);
            ovfQ    <= 1'b0;
        end else if ((state == RUN) && lastIter) begin
            ovfQ <= ovfPend;
        end
    end

    assign divIf.ovf = ovfQ;
`else
    assign divIf.ovf = 1'b0;
`endif

    assign divIf.busy      = (state != IDLE);
    assign divIf.done      = (state == DONE);
    assign divIf.quotient  = quotientQ;
    assign divIf.remainder = remainderQ;
    assign divIf.dbz       = dbzQ;

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: table-driven, hand-sequenced and random checks of restoring_divider (N=8).
// Latency: expects done in the (N+1)th busy cycle, or the first one for divide-by-zero.
// Backpressure: exercises start while busy and back-to-back starts in the first idle cycle.
module tb_restoring_divider;

    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    restoring_divider_if #(.N(N)) dif ();

    restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .divIf (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        logic       o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands as numbers.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z, output logic o);
`ifdef RESTORING_DIVIDER_SIGNED_EN
        int sa;
        int sb;
        int sq;
        int sr;
`endif
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
            o = 1'b0;
        end else begin
            z = 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[7:0];
            r  = sr[7:0];
            o  = (sa == -128) && (sb == -1);
`else
            q = a / b;
            r = a % b;
            o = 1'b0;
`endif
        end
    endfunction

    // Issues a start in the next cycle, then watches cycles after the accepting edge
    // (cycle 0 = first cycle after it) until done or the cycle budget runs out.
    task automatic runDiv(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic z, output logic o,
                          output int busyCyc, output int doneCyc);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        #1 dif.start = 1'b0;
        busyCyc = 0;
        doneCyc = -1;
        q = '0;
        r = '0;
        z = 1'b0;
        o = 1'b0;
        for (int c = 0; c < 40 && doneCyc < 0; c++) begin
            @(negedge clk);
            if (dif.busy) busyCyc++;
            if (dif.done) begin
                doneCyc = c;
                q = dif.quotient;
                r = dif.remainder;
                z = dif.dbz;
                o = dif.ovf;
            end
        end
    endtask

    task automatic applyAndCheck(input string tag, input vec_t v);
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        logic       o;
        int         busyCyc;
        int         doneCyc;
        int         expDone;
        runDiv(v.a, v.b, q, r, z, o, busyCyc, doneCyc);
        expDone = v.z ? 0 : N;
        check({tag, " doneCycle"}, doneCyc, expDone);
        check({tag, " busyCycles"}, busyCyc, expDone + 1);
        check({tag, " quotient"}, 32'(q), 32'(v.q));
        check({tag, " remainder"}, 32'(r), 32'(v.r));
        check({tag, " dbz"}, 32'(z), 32'(v.z));
        check({tag, " ovf"}, 32'(o), 32'(v.o));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       table_v[$];
        vec_t       v;
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        logic       eo;
        int         doneSeen;
        int         doneCyc;

        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;

`ifdef RESTORING_DIVIDER_SIGNED_EN
        table_v.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0});  // -7 / 2
        table_v.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0});  // 7 / -2
        table_v.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1});  // -128 / -1
        table_v.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0});  // -128 / 1
        table_v.push_back('{8'd100, 8'd0, 8'hFF, 8'd100, 1'b1, 1'b0}); // divide by zero
        table_v.push_back('{8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 1'b0});
`else
        table_v.push_back('{8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0});
        table_v.push_back('{8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0});
        table_v.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0});  // back-to-back
        table_v.push_back('{8'd100, 8'd0, 8'hFF, 8'd100, 1'b1, 1'b0}); // divide by zero
        table_v.push_back('{8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 1'b0});
        table_v.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", 32'(dif.busy), 0);
        check("reset done", 32'(dif.done), 0);
        check("reset quotient", 32'(dif.quotient), 0);
        check("reset remainder", 32'(dif.remainder), 0);
        check("reset dbz", 32'(dif.dbz), 0);
        check("reset ovf", 32'(dif.ovf), 0);
        rst_n = 1'b1;

        // Table vectors, issued back-to-back (each start in the first idle cycle)
        for (int i = 0; i < table_v.size(); i++) begin
            applyAndCheck($sformatf("vec%0d", i), table_v[i]);
        end

        // start during RUN and during DONE must be ignored
        model(8'd200, 8'd7, eq, er, ez, eo);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 8'd200;
        dif.divisor  = 8'd7;
        @(posedge clk);
        #1 dif.start = 1'b0;
        doneCyc = -1;
        for (int c = 0; c < 40 && doneCyc < 0; c++) begin
            @(negedge clk);
            dif.dividend = 8'd50;
            dif.divisor  = 8'd5;
            if (dif.done) begin
                doneCyc = c;
                check("ignore quotient@done", 32'(dif.quotient), 32'(eq));
                check("ignore remainder@done", 32'(dif.remainder), 32'(er));
                dif.start = 1'b1;
            end else begin
                dif.start = (c == 3);
            end
        end
        check("ignore doneCycle", doneCyc, N);
        @(posedge clk);
        #1 dif.start = 1'b0;
        @(negedge clk);
        check("ignore busy after done", 32'(dif.busy), 0);
        check("hold quotient", 32'(dif.quotient), 32'(eq));
        check("hold remainder", 32'(dif.remainder), 32'(er));

        // Reset in the middle of a division: immediate clear, no done pulse
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 8'd200;
        dif.divisor  = 8'd7;
        @(posedge clk);
        #1 dif.start = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);                 // cycle 4 after accept
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(dif.busy), 0);
        check("abort done", 32'(dif.done), 0);
        check("abort quotient", 32'(dif.quotient), 0);
        check("abort remainder", 32'(dif.remainder), 0);
        check("abort dbz", 32'(dif.dbz), 0);
        doneSeen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 3) rst_n = 1'b1;
            if (dif.done) doneSeen++;
        end
        check("abort no done pulse", doneSeen, 0);
        model(8'd9, 8'd2, v.q, v.r, v.z, v.o);
        v.a = 8'd9;
        v.b = 8'd2;
        check("model 9/2 quotient", 32'(v.q), 4);
        applyAndCheck("after abort 9/2", v);

        // Random operands against the reference model
        for (int i = 0; i < 150; i++) begin
            v.a = 8'($urandom);
            v.b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            model(v.a, v.b, v.q, v.r, v.z, v.o);
            applyAndCheck($sformatf("rnd%0d %0d/%0d", i, v.a, v.b), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
